// File: rtl/lab4_pkg.sv
// Shared definitions for the lab datapath rotators.
package lab4_pkg;

  // Default geometry, shared with the rotate-right register.
  localparam int WIDTH_DEF = 16;
  localparam int CW_DEF    = 4;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rot_cnt.sv
// Loadable down-counter for the rotate amount, with a flag on the last step.
module rot_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  // Load takes priority; decrement only while the rotator is stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
    end
  end

  // The step taken while cnt==1 is the final rotation.
  assign last = (cnt == CW'(1));

endmodule

// File: rtl/rotl16_seq.sv
// Sequential left-rotator: loads a word, rotates it left one bit per clock
// Size times, then pulses done. Undoes a right rotation of the same amount.
//
// Handshake: start is a request sampled only in IDLE (D and Size captured on
// the same edge); busy is high while rotating; done is a one-cycle pulse with
// the result valid on Q. Requests outside IDLE are dropped, never queued.
import lab4_pkg::*;

module rotl16_seq #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             R_n,
  input  logic             start,
  input  logic [CW-1:0]    Size,
  input  logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output state_t           dbg_state
);

  state_t        state_q;
  state_t        state_d;
  logic          load;
  logic          rot;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  rot_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (R_n),
    .load     (load),
    .load_val (Size),
    .dec      (rot),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rot     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (Size != '0) ? ROT : DONE;
        end
      end
      ROT: begin
        rot = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Working register: capture on load, rotate left with MSB wrapping to bit 0.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      Q <= '0;
    end else if (load) begin
      Q <= D;
    end else if (rot) begin
      Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
    end
  end

  // Moore outputs, decoded from state only.
  assign busy      = (state_q == ROT);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

  // cnt is only consumed through the terminal flag.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: doc/rotl16_seq.md
Name: rotl16_seq

Overview:
- Sequential left-rotator: the inverse of the team's right-rotate shift register.
- Loads a WIDTH-bit word, rotates it left by Size positions (one bit per clock), then reports done.
- Used to undo a prior right rotation of the same amount. Sits beside the rotate-right register in the lab datapath.
- Start/busy/done handshake to the controlling FSM.

Parameters:
- WIDTH, 16, data word width in bits.
- CW, 4, width of Size; must satisfy 2^CW <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- R_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- Size  input  CW  rotate amount, 0..2^CW-1; sampled with start.
- D  input  WIDTH  word to rotate; sampled with start.
- busy  output  1  high while rotating.
- done  output  1  one-cycle pulse; result valid on Q.
- Q  output  WIDTH  working/result register.

Behaviour:
- Reset (R_n low, async):
  - state=IDLE, Q=0, cnt=0, busy=0, done=0.
  - Takes effect immediately, including mid-rotation. The partial result is discarded.
- Registered state: 2-bit state {IDLE, ROT, DONE}, CW-bit down-counter cnt, Q.
- IDLE:
  - On a clock edge with start=1: Q<=D, cnt<=Size.
  - state<=ROT if Size!=0, else state<=DONE.
  - With start=0: Q holds its value (previous result stays readable).
- ROT, every edge:
  - Q<={Q[WIDTH-2:0],Q[WIDTH-1]} (MSB wraps to bit 0), cnt<=cnt-1.
  - If cnt==1, state<=DONE.
- DONE: state<=IDLE unconditionally. Q holds.
- Outputs are Moore-decoded from state, with no combinational path from inputs:
  - busy = (state==ROT).
  - done = (state==DONE).
- Latency:
  - Load edge = edge 0; done is high in the cycle after edge Size. Size=0 gives done in the cycle right after the load edge.
  - Start-to-start throughput is Size+2 cycles.
- start while busy or done: ignored. No queuing, no effect on Q or Size.
- start held high continuously: a new operation is accepted each time the FSM returns to IDLE (back-to-back).
- Size and D may change freely after the load edge. Only the values sampled at load matter.
- Size=2^CW-1 with WIDTH=16 rotates 15 times; equivalent to rotate-right by 1.
- No arithmetic beyond the cnt decrement. cnt never underflows because ROT is entered only with cnt>=1.

Decomposition:
- Shared package (lab4_pkg) holds:
  - the state encoding constants IDLE=2'd0, ROT=2'd1, DONE=2'd2;
  - the default WIDTH/CW values, shared with the rotate-right register.
- One natural sub-module: rot_cnt, the loadable CW-bit down-counter with a terminal flag (cnt==1).
- The FSM and the Q shifter stay in the top level.

Test Plan:
- Reset: assert R_n=0 mid-cycle with Q holding data → Q=0x0000, busy=0, done=0 immediately, without waiting for a clock edge.
- Size=0, D=0xBEEF, pulse start → done high in the cycle after load, busy never high, Q=0xBEEF.
- Rotate cases, each done exactly Size cycles after load:
  - Size=3, D=0x8001 → busy for 3 cycles, then done, Q=0x000C.
  - Size=4, D=0x1234 → Q=0x2341.
- Size=15, D=0x0001 → Q=0x8000 after 15 busy cycles.
- Ignored start: pulse start with D=0xFFFF, Size=7 while busy on a Size=5, D=0x00F0 job → result Q=0x1E00, one done pulse only.
- Abort and round trip:
  - Drop R_n during ROT of Size=9 → Q=0, state IDLE.
  - Next start with Size=2, D=0x4000 → Q=0x0001.
  - Round trip: right-rotate 0xA5C3 by 5 in the existing register, feed the result here with Size=5 → Q=0xA5C3.
